// File: rtl/rps_round_judge.sv
// Round judge for rock-paper-scissors: freezes the CPU choice generator, captures
// both moves, judges the round, keeps saturating scores and ends the match at WIN_TARGET.
module rps_round_judge #(
  parameter int SHOW_CYCLES = 4,
  parameter int WIN_TARGET  = 3,
  parameter int SCORE_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               player_valid,
  input  logic [1:0]         player_choice,
  input  logic               new_match,
  input  logic [1:0]         cpu_choice,
  output logic               stop_signal,
  output logic               busy,
  output logic               result_valid,
  output logic [1:0]         result,
  output logic [1:0]         player_move_q,
  output logic [1:0]         cpu_move_q,
  output logic [SCORE_W-1:0] player_score,
  output logic [SCORE_W-1:0] cpu_score,
  output logic               match_done,
  output logic               match_winner
);

  localparam int CNT_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOCK  = 3'd1,
    S_JUDGE = 3'd2,
    S_SHOW  = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               stop_q, stop_d;
  logic               busy_q, busy_d;
  logic               rv_q, rv_d;
  logic [1:0]         res_q, res_d;
  logic [1:0]         pm_q, pm_d;
  logic [1:0]         cm_q, cm_d;
  logic [SCORE_W-1:0] ps_q, ps_d;
  logic [SCORE_W-1:0] cs_q, cs_d;
  logic               done_q, done_d;
  logic               win_q, win_d;
  logic [1:0]         judged_s;

  // (player - cpu) mod 3 maps directly onto the result code: 0 tie, 1 player, 2 cpu
  function automatic logic [1:0] judge(input logic [1:0] p, input logic [1:0] c);
    logic [2:0] d;
    d = {1'b0, p} + 3'd3 - {1'b0, c};
    if (d >= 3'd3) begin
      d = d - 3'd3;
    end else begin
      d = d;
    end
    return d[1:0];
  endfunction

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    if (s == {SCORE_W{1'b1}}) begin
      return s;
    end else begin
      return s + SCORE_W'(1);
    end
  endfunction

  assign judged_s = judge(pm_q, cm_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rv_d    = 1'b0;
    res_d   = res_q;
    pm_d    = pm_q;
    cm_d    = cm_q;
    ps_d    = ps_q;
    cs_d    = cs_q;
    done_d  = done_q;
    win_d   = win_q;
    if (new_match) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      res_d   = 2'b00;
      pm_d    = 2'b00;
      cm_d    = 2'b00;
      ps_d    = '0;
      cs_d    = '0;
      done_d  = 1'b0;
      win_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (player_valid && (player_choice != 2'b11)) begin
            pm_d    = player_choice;
            state_d = S_LOCK;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LOCK: begin
          cm_d    = (cpu_choice == 2'b11) ? 2'b00 : cpu_choice;
          state_d = S_JUDGE;
        end
        S_JUDGE: begin
          res_d = judged_s;
          rv_d  = 1'b1;
          if (judged_s == 2'b01) begin
            ps_d = sat_inc(ps_q);
          end else if (judged_s == 2'b10) begin
            cs_d = sat_inc(cs_q);
          end else begin
            ps_d = ps_q;
          end
          cnt_d   = CNT_W'(SHOW_CYCLES);
          state_d = S_SHOW;
        end
        S_SHOW: begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d = '0;
            if ((ps_q >= SCORE_W'(WIN_TARGET)) || (cs_q >= SCORE_W'(WIN_TARGET))) begin
              state_d = S_OVER;
              done_d  = 1'b1;
              win_d   = (cs_q >= SCORE_W'(WIN_TARGET));
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_OVER: begin
          state_d = S_OVER;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    // generator stays frozen in every state but IDLE
    stop_d = (state_d != S_IDLE);
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
      res_q   <= 2'b00;
      pm_q    <= 2'b00;
      cm_q    <= 2'b00;
      ps_q    <= '0;
      cs_q    <= '0;
      done_q  <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      busy_q  <= busy_d;
      rv_q    <= rv_d;
      res_q   <= res_d;
      pm_q    <= pm_d;
      cm_q    <= cm_d;
      ps_q    <= ps_d;
      cs_q    <= cs_d;
      done_q  <= done_d;
      win_q   <= win_d;
    end
  end

  assign stop_signal   = stop_q;
  assign busy          = busy_q;
  assign result_valid  = rv_q;
  assign result        = res_q;
  assign player_move_q = pm_q;
  assign cpu_move_q    = cm_q;
  assign player_score  = ps_q;
  assign cpu_score     = cs_q;
  assign match_done    = done_q;
  assign match_winner  = win_q;

endmodule

// File: tb/tb_rps_round_judge.sv
// Bench for rps_round_judge: a round-timeline model checked every cycle, plus
// directed rounds with hand-computed results.
module tb_rps_round_judge;
  localparam int SHOW = 4;
  localparam int TGT  = 3;
  localparam int SW   = 4;
  localparam int MAXS = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic player_valid = 1'b0;
  logic [1:0] player_choice = 2'b00;
  logic new_match = 1'b0;
  logic [1:0] cpu_choice = 2'b00;
  logic stop_signal, busy, result_valid, match_done, match_winner;
  logic [1:0] result, player_move_q, cpu_move_q;
  logic [SW-1:0] player_score, cpu_score;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  rps_round_judge #(.SHOW_CYCLES(SHOW), .WIN_TARGET(TGT), .SCORE_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .player_valid(player_valid), .player_choice(player_choice),
    .new_match(new_match), .cpu_choice(cpu_choice), .stop_signal(stop_signal), .busy(busy),
    .result_valid(result_valid), .result(result), .player_move_q(player_move_q),
    .cpu_move_q(cpu_move_q), .player_score(player_score), .cpu_score(cpu_score),
    .match_done(match_done), .match_winner(match_winner)
  );

  always #5 clk = ~clk;

  // Model: age counts edges since a move was accepted (-1 when no round is running)
  typedef struct {
    int age; bit over; int ps; int cs; int pm; int cm; int res; bit rv; bit winner;
  } model_t;
  model_t m;

  function automatic model_t idle_m();
    model_t n;
    n.age = -1; n.over = 0; n.ps = 0; n.cs = 0; n.pm = 0; n.cm = 0;
    n.res = 0; n.rv = 0; n.winner = 0;
    return n;
  endfunction

  function automatic model_t step(model_t cur, bit nm, bit pv, int pc, int cpu);
    model_t n;
    int d;
    n = cur;
    n.rv = 0;
    if (nm) begin
      n = idle_m();
    end else if (n.over) begin
      n.over = 1;
    end else if (n.age < 0) begin
      if (pv && pc != 3) begin n.pm = pc; n.age = 1; end
    end else begin
      if (n.age == 1) n.cm = (cpu == 3) ? 0 : cpu;
      if (n.age == 2) begin
        d = (((n.pm - n.cm) % 3) + 3) % 3;
        n.res = d; n.rv = 1;
        if (d == 1) n.ps = (n.ps < MAXS) ? n.ps + 1 : MAXS;
        if (d == 2) n.cs = (n.cs < MAXS) ? n.cs + 1 : MAXS;
      end
      n.age = n.age + 1;
      if (n.age == 3 + SHOW) begin
        n.age = -1;
        if (n.ps >= TGT || n.cs >= TGT) begin n.over = 1; n.winner = (n.cs >= TGT); end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= idle_m();
    else m <= step(m, new_match, player_valid, int'(player_choice), int'(cpu_choice));
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_stop", stop_signal, (m.age >= 0 || m.over) ? 1 : 0);
      chk("m_busy", busy, (m.age >= 0 || m.over) ? 1 : 0);
      chk("m_rv", result_valid, m.rv);
      chk("m_result", result, m.res);
      chk("m_pmove", player_move_q, m.pm);
      chk("m_cmove", cpu_move_q, m.cm);
      chk("m_pscore", player_score, m.ps);
      chk("m_cscore", cpu_score, m.cs);
      chk("m_done", match_done, m.over);
      chk("m_winner", match_winner, m.winner);
    end
  end

  task automatic pulse_new_match();
    @(negedge clk) new_match = 1'b1;
    @(negedge clk) new_match = 1'b0;
  endtask

  task automatic play_round(input logic [1:0] p, input logic [1:0] c, input bit inject,
                            output logic [1:0] r);
    int lat;
    int n;
    @(negedge clk);
    cpu_choice = c; player_choice = p; player_valid = 1'b1;
    @(negedge clk);
    player_valid = 1'b0;
    lat = 1;
    while (!result_valid && lat < 10) begin @(negedge clk); lat++; end
    chk("latency", lat, 3);
    r = result;
    if (inject) begin
      player_choice = 2'b10; player_valid = 1'b1;
      @(negedge clk);
      player_valid = 1'b0;
    end
    n = 0;
    while (busy && !match_done && n < 30) begin @(negedge clk); n++; end
    chk("round_end_timeout", (n < 30) ? 1 : 0, 1);
  endtask

  logic [1:0] tbl [9] = '{2'd0, 2'd2, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd1, 2'd0};

  initial begin
    logic [1:0] r;
    int ties, pw, cw, n;
    repeat (3) @(negedge clk);
    chk("rst_stop", stop_signal, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_scores", {player_score, cpu_score}, 0);
    chk("rst_done", match_done, 0);
    @(negedge clk) rst_n = 1'b1;
    chk_en = 1'b1;

    // Paper vs frozen rock
    play_round(2'd1, 2'd0, 1'b0, r);
    chk("first_result", r, 1);
    chk("first_pscore", player_score, 1);
    chk("first_cmove", cpu_move_q, 0);

    // Full outcome matrix
    ties = 0; pw = 0; cw = 0;
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 3; c++) begin
        pulse_new_match();
        play_round(2'(p), 2'(c), 1'b0, r);
        chk("matrix", r, tbl[p * 3 + c]);
        if (r == 2'd0) ties++; else if (r == 2'd1) pw++; else cw++;
      end
    end
    chk("ties", ties, 3);
    chk("pwins", pw, 3);
    chk("cwins", cw, 3);

    // Illegal move in IDLE
    pulse_new_match();
    @(negedge clk) begin player_choice = 2'b11; player_valid = 1'b1; end
    @(negedge clk) player_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("illegal_stop", stop_signal, 0);
    chk("illegal_busy", busy, 0);

    // Illegal cpu choice captured as rock
    play_round(2'd1, 2'd3, 1'b0, r);
    chk("cpu11_result", r, 1);
    chk("cpu11_cmove", cpu_move_q, 0);

    // Strobe during SHOW is dropped
    pulse_new_match();
    play_round(2'd1, 2'd0, 1'b1, r);
    chk("drop_pscore", player_score, 1);
    chk("drop_cscore", cpu_score, 0);
    @(negedge clk);
    chk("drop_busy", busy, 0);

    // CPU wins the match
    pulse_new_match();
    for (int k = 0; k < 3; k++) play_round(2'd2, 2'd0, 1'b0, r);
    chk("over_done", match_done, 1);
    chk("over_winner", match_winner, 1);
    chk("over_cscore", cpu_score, 3);
    chk("over_stop", stop_signal, 1);
    @(negedge clk) begin player_choice = 2'd1; player_valid = 1'b1; end
    @(negedge clk) player_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("over_hold_c", cpu_score, 3);
    chk("over_hold_p", player_score, 0);
    chk("over_hold_done", match_done, 1);

    // new_match during LOCK
    pulse_new_match();
    play_round(2'd1, 2'd0, 1'b0, r);
    @(negedge clk) begin player_choice = 2'd1; player_valid = 1'b1; end
    @(negedge clk) begin player_valid = 1'b0; new_match = 1'b1; end
    @(negedge clk) new_match = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_stop", stop_signal, 0);
    chk("abort_pscore", player_score, 0);

    // Async reset mid-SHOW
    @(negedge clk) begin player_choice = 2'd1; player_valid = 1'b1; end
    @(negedge clk) player_valid = 1'b0;
    n = 0;
    while (!result_valid && n < 10) begin @(negedge clk); n++; end
    chk("rst_wait", (n < 10) ? 1 : 0, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_stop", stop_signal, 0);
    chk("arst_busy", busy, 0);
    chk("arst_pscore", player_score, 0);
    chk("arst_result", result, 0);
    @(negedge clk) rst_n = 1'b1;
    play_round(2'd0, 2'd2, 1'b0, r);
    chk("rearm_result", r, 1);
    chk("rearm_pscore", player_score, 1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
